// File: rtl/out_port_scheduler.sv
// Per-output-port scheduler: round-robin arbitration of four input channels
// onto one downstream output buffer, one registered write per two cycles.
module out_port_scheduler #(
  parameter int DW   = 64,
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req_vld,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [DW-1:0] req_data2,
  input  logic [DW-1:0] req_data3,
  input  logic          out_empty,
  output logic [3:0]    req_ack,
  output logic          out_wr,
  output logic [DW-1:0] out_data,
  output logic [1:0]    grant_id,
  output logic          busy
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [3:0]    ack_nxt;
  logic          wr_nxt;
  logic [DW-1:0] data_nxt;
  logic [1:0]    gid_nxt;
  logic [1:0]    idx;
  logic [1:0]    win;
  logic          found;
  logic [DW-1:0] req_data [NREQ];

  assign req_data[0] = req_data0;
  assign req_data[1] = req_data1;
  assign req_data[2] = req_data2;
  assign req_data[3] = req_data3;

  // HOLD lasts exactly one cycle, giving out_empty time to settle after a write
  assign busy = (state == HOLD);

  // Round-robin search from ptr, then next-state and next-output decode
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ack_nxt   = '0;
    wr_nxt    = 1'b0;
    data_nxt  = out_data;
    gid_nxt   = grant_id;
    idx       = '0;
    win       = '0;
    found     = 1'b0;
    // Walk the search order backwards so the closest requester to ptr wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    case (state)
      ARB: begin
        if (out_empty && found) begin
          state_nxt = HOLD;
          ptr_nxt   = win + 2'd1;
          ack_nxt   = 4'b0001 << win;
          wr_nxt    = 1'b1;
          data_nxt  = req_data[win];
          gid_nxt   = win;
        end
      end
      HOLD: begin
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // State and registered outputs; reset abandons any pending transfer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB;
      ptr      <= '0;
      req_ack  <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      req_ack  <= ack_nxt;
      out_wr   <= wr_nxt;
      out_data <= data_nxt;
      grant_id <= gid_nxt;
    end
  end

endmodule

// File: tb/tb_out_port_scheduler.sv
// Self-checking bench for out_port_scheduler: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_out_port_scheduler;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_vld;
  logic [DW-1:0] d [4];
  logic          out_empty;
  logic [3:0]    req_ack;
  logic          out_wr;
  logic [DW-1:0] out_data;
  logic [1:0]    grant_id;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int            m_ptr  = 0;
  bit            m_hold = 1'b0;
  logic [3:0]    e_ack  = '0;
  logic          e_wr   = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic [1:0]    e_gid  = '0;
  logic          e_busy = 1'b0;

  logic [DW-1:0] seen_data [$];
  logic [3:0]    seen_ack  [$];

  out_port_scheduler #(.DW(DW), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_data0 (d[0]),
    .req_data1 (d[1]),
    .req_data2 (d[2]),
    .req_data3 (d[3]),
    .out_empty (out_empty),
    .req_ack   (req_ack),
    .out_wr    (out_wr),
    .out_data  (out_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: what the outputs must be after the coming edge, given the inputs
  task automatic model_edge();
    int w;
    if (!rst) begin
      m_ptr = 0; m_hold = 1'b0;
      e_ack = '0; e_wr = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0;
    end else if (m_hold) begin
      m_hold = 1'b0;
      e_ack = '0; e_wr = 1'b0; e_busy = 1'b0;
    end else if (out_empty && req_vld != 4'b0000) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req_vld[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      e_ack  = 4'(1 << w);
      e_wr   = 1'b1;
      e_data = d[w];
      e_gid  = 2'(w);
      e_busy = 1'b1;
      m_ptr  = (w + 1) % 4;
      m_hold = 1'b1;
    end else begin
      e_ack = '0; e_wr = 1'b0; e_busy = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic e);
    @(negedge clk);
    rst = r; req_vld = v; out_empty = e;
    model_edge();
    @(posedge clk);
    #1;
    chk("req_ack",  DW'(req_ack),  DW'(e_ack));
    chk("out_wr",   DW'(out_wr),   DW'(e_wr));
    chk("out_data", out_data,      e_data);
    chk("grant_id", DW'(grant_id), DW'(e_gid));
    chk("busy",     DW'(busy),     DW'(e_busy));
    if (out_wr) begin
      seen_data.push_back(out_data);
      seen_ack.push_back(req_ack);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_rot_data [5];
    logic [3:0]    exp_rot_ack  [5];
    exp_rot_data = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h10};
    exp_rot_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b0; req_vld = '0; out_empty = 1'b0;
    for (int n = 0; n < 4; n++) d[n] = DW'(n + 'h10);

    // Reset held with all requesters active and an empty buffer
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);

    // Full rotation
    seen_data.delete(); seen_ack.delete();
    for (int n = 0; n < 10; n++) step(1'b1, 4'b1111, 1'b1);
    chk("rot_count", DW'(seen_data.size()), DW'(5));
    for (int n = 0; n < 5 && n < seen_data.size(); n++) begin
      chk("rot_data", seen_data[n], exp_rot_data[n]);
      chk("rot_ack",  DW'(seen_ack[n]), DW'(exp_rot_ack[n]));
    end

    // Sparse and wrap: win by requester 2 leaves ptr=3, then 0 and 1 compete
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    chk("sparse_g2", DW'(req_ack), DW'(4'b0100));
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0011, 1'b1);
    chk("wrap_g0", DW'(req_ack), DW'(4'b0001));
    step(1'b1, 4'b0011, 1'b1);
    step(1'b1, 4'b0011, 1'b1);
    chk("wrap_g1", DW'(req_ack), DW'(4'b0010));
    step(1'b1, 4'b0000, 1'b1);

    // Backpressure
    for (int n = 0; n < 5; n++) step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b1);
    chk("bp_ack",  DW'(req_ack), DW'(4'b0100));
    chk("bp_busy", DW'(busy),    DW'(1'b1));
    step(1'b1, 4'b0000, 1'b1);

    // Reset on the cycle the grant condition is met
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    chk("rst_mid_wr", DW'(out_wr), DW'(1'b0));
    step(1'b1, 4'b1111, 1'b1);
    chk("rst_first_g0", DW'(req_ack), DW'(4'b0001));
    step(1'b1, 4'b0000, 1'b1);

    // Single requester streaming with fresh data after each ack
    for (int n = 0; n < 8; n++) begin
      if (req_ack[3]) d[3] = {$urandom, $urandom};
      step(1'b1, 4'b1000, 1'b1);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < 4; j++) d[j] = {$urandom, $urandom};
      step(($urandom_range(0, 39) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/out_port_scheduler.md
Name: out_port_scheduler

Overview:
- Per-output-port scheduler for the router: shares one downstream output buffer between four input channels.
- Arbitrates in round-robin order, registers the winner's flit into the output stage, and acknowledges the winner.
- Sequences writes so the downstream buffer's empty flag has one cycle to settle before the next arbitration.
- One instance per router output direction; sits between the input channel buffers and the output buffer.

Parameters:
DW, 64, flit width in bits
NREQ, 4, number of requesters; fixed at 4, not to be overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-low reset
req_vld  in  4  per-requester flit valid; bit i belongs to requester i
req_data0  in  DW  flit from requester 0
req_data1  in  DW  flit from requester 1
req_data2  in  DW  flit from requester 2
req_data3  in  DW  flit from requester 3
out_empty  in  1  1 = downstream output buffer is empty and can accept one flit
req_ack  out  4  registered one-hot; a one-cycle pulse to the requester whose flit was taken
out_wr  out  1  registered one-cycle write strobe to the downstream buffer
out_data  out  DW  registered flit; valid when out_wr=1
grant_id  out  2  index of the last granted requester
busy  out  1  1 while the state machine is in HOLD

Behaviour:
- Reset: when rst=0 at a rising edge, the block returns to its reset state regardless of the current state.
  - state=ARB, ptr=0.
  - req_ack=0, out_wr=0, out_data=0, grant_id=0, busy=0.
  - A transfer in flight is abandoned: no ack and no write after reset.
- State machine: two states, ARB and HOLD.
- ARB, grant condition: out_empty=1 and req_vld!=0.
  - Winner = first set bit of req_vld, searching ptr, ptr+1, ... mod 4.
  - At the next edge: out_wr=1, out_data=req_dataW sampled at that edge, req_ack=1<<W.
  - Also at that edge: grant_id=W, ptr=(W+1) mod 4, state=HOLD, busy=1.
- ARB, no-grant condition: out_empty=0 or req_vld=0.
  - Stay in ARB; out_wr=0, req_ack=0.
  - out_data and grant_id hold their previous values; ptr unchanged.
- HOLD: unconditional.
  - At the next edge: out_wr=0, req_ack=0, busy=0, state=ARB.
  - No sampling of req_vld or out_empty in HOLD.
- Latency and throughput:
  - 1 cycle from the grant condition to out_wr/req_ack.
  - Maximum throughput is one flit per 2 cycles.
- Requester contract:
  - req_vld and req_dataN must stay stable until req_ack[N] is seen.
  - The requester pops its flit on the edge ending the ack cycle.
  - HOLD guarantees the same flit is never granted twice.
- Pointer wrap: a win by requester 3 sets ptr=0.
- Simultaneous requests: only one winner per arbitration; the losers keep requesting and are served in rotation.
  - Each active requester waits at most 3 grants.
- out_empty dropping while in HOLD: no effect; it is checked at the next ARB cycle.
- req_vld deasserted by a requester before it is acked: legal; that requester is simply not considered.
- Invariants:
  - req_ack is zero or one-hot.
  - out_wr == |req_ack in every cycle.
  - grant_id equals the index of the set req_ack bit whenever req_ack!=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_vld=4'b1111 and out_empty=1 -> out_wr=0, req_ack=0, out_data=0, grant_id=0 throughout; the first grant after rst=1 goes to requester 0.
- Full rotation: req_vld=4'b1111 held, out_empty=1, req_dataN=N+0x10 -> acks in order 0001,0010,0100,1000,0001 on alternating cycles; out_data 0x10,0x11,0x12,0x13,0x10.
- Sparse and wrap: ptr=3 after a grant to requester 2, then req_vld=4'b0011 -> grant requester 0 (ack=0001), then requester 1; never requester 0 twice in a row while requester 1 is waiting.
- Backpressure: req_vld=4'b0100 with out_empty=0 for 5 cycles -> no out_wr or ack; out_empty=1 -> out_wr and req_ack=0100 exactly 1 cycle later, then busy=1 for that cycle.
- Reset mid-transfer: rst=0 on the cycle the grant condition is met -> next cycle out_wr=0, req_ack=0, ptr=0; no flit is written.
- Single requester streaming: req_vld=4'b1000 continuously with new data after each ack, out_empty=1 -> out_wr on every second cycle, grant_id=3 each time, ptr stays 0 after each grant.
